mtl_frame_writer: RTL and testbench
===================================

Name: mtl_frame_writer

Overview:
- Write side of the MTL slideshow frame buffer. Receives the pixel byte stream sent by the PIC32 through the SPI byte interface.
- Assembles R,G,B bytes into 32-bit pixel words and issues sequential write requests to the SDRAM write port. The LCD controller later reads these words back in the same 0x00RRGGBB layout.
- Drives the loading flag that tells the LCD controller when a slideshow load is in progress.

Parameters:
- H_ACTIVE, 800, active pixels per line
- V_ACTIVE, 480, active lines per frame
- N_FRAMES, 8, slideshow frames held in SDRAM
- ADDR_W, 22, SDRAM word address width; must satisfy N_FRAMES*H_ACTIVE*V_ACTIVE <= 2^ADDR_W
- HDR_BYTE, 8'hA5, frame-start header value

Ports:
- iCLK  in  1  system clock (same domain as the LCD controller)
- iRST_n  in  1  asynchronous active-low reset
- iCS_n  in  1  SPI chip select, already synchronised to iCLK; high = link idle
- iBYTE  in  8  received SPI byte
- iBYTE_VALID  in  1  one-cycle strobe, iBYTE valid
- iWR_FULL  in  1  SDRAM write FIFO full
- oWR_EN  out  1  write request; oWR_DATA/oWR_ADDR valid
- oWR_DATA  out  32  {8'h00,R,G,B}
- oWR_ADDR  out  ADDR_W  frame*H_ACTIVE*V_ACTIVE + pixel index
- oLoading  out  1  high while a frame load is in progress
- oFrameDone  out  1  one-cycle pulse when the last pixel of a frame is written
- oErr  out  1  sticky error flag (overflow, abort, or bad frame index)

Behaviour:
- Reset (async): state IDLE. All outputs 0. Counters, byte phase and the skid register are cleared.
- FSM states: IDLE, GET_IDX, LOAD, FLUSH.
  - IDLE: iBYTE_VALID with iBYTE==HDR_BYTE -> GET_IDX. Any other byte is ignored.
  - GET_IDX: next valid byte is the frame index.
    - Index < N_FRAMES: latch frame base = idx*H_ACTIVE*V_ACTIVE, clear pixel counter and byte phase, set oLoading, go to LOAD.
    - Index >= N_FRAMES: set oErr, return to IDLE.
  - LOAD: byte phase cycles 0->1->2 on each valid byte, storing R, G, B in that order. On phase 2 the pixel is complete and the pixel counter increments.
  - Last pixel complete (counter == H_ACTIVE*V_ACTIVE-1): go to FLUSH if a write is still pending, otherwise pulse oFrameDone and go to IDLE.
  - FLUSH: wait until the pending pixel is written, then pulse oFrameDone, clear oLoading, go to IDLE.
- Write handshake:
  - A word is transferred in a cycle where oWR_EN=1 and iWR_FULL=0.
  - While oWR_EN=1 and iWR_FULL=1, oWR_EN/oWR_DATA/oWR_ADDR hold stable.
  - oWR_EN rises one cycle after the B byte strobe (registered output, latency 1).
- Buffering:
  - One pending-word register plus one skid entry, so two assembled pixels may wait on iWR_FULL.
  - A third completed pixel while both are occupied is dropped and sets oErr. The counter still advances, so the frame address stays aligned.
  - The SPI link cannot be stalled.
- Address arithmetic:
  - Pixel counter is 19 bits for the default parameters; width = clog2(H_ACTIVE*V_ACTIVE).
  - Address = base + counter, computed in ADDR_W bits with no wrap. Bases are precomputed with constant multiplication.
- oLoading:
  - Set on entry to LOAD, cleared when the FSM returns to IDLE.
  - Consecutive frames in one session: oLoading may drop for a single cycle between frames; the LCD controller only samples it at frame starts.
- Abort: a rising edge of iCS_n in GET_IDX or LOAD:
  - sets oErr, clears oLoading, discards the partial pixel, goes to IDLE;
  - already-queued complete pixels are still written.
- Simultaneous events:
  - B-byte completion in the same cycle a queued word is accepted: the new word moves into the freed slot, with no loss.
  - Header byte values inside LOAD are treated as pixel data.
- oErr clears only on reset.

Decomposition:
- Package mtl_pkg holds:
  - fsm enum (IDLE, GET_IDX, LOAD, FLUSH);
  - localparams FRAME_PIXELS = H_ACTIVE*V_ACTIVE and PIX_CNT_W;
  - the pixel word layout constant shared with the LCD controller: red [23:16], green [15:8], blue [7:0].
- One natural sub-module: mtl_wr_skid, a 2-entry word+address skid buffer with a valid/full handshake toward the SDRAM FIFO.

Test Plan:
- Reset mid-LOAD after 100 pixels -> all outputs 0 immediately; afterwards A5,00 restarts at oWR_ADDR=0.
- Bytes A5,02 then 3 bytes 11,22,33 -> oLoading=1 after the index byte; oWR_EN for one cycle with oWR_DATA=0x00112233 and oWR_ADDR=768000.
- Full frame A5,00 with 384000*3 bytes and iWR_FULL=0 -> 384000 writes at addresses 0..383999; oFrameDone pulses once after the last write; oLoading=0 afterwards; oErr=0.
- iWR_FULL held high across 2 completed pixels, then released -> both words are written in order with addresses n and n+1, oErr=0. A 3rd pixel during the stall -> oErr=1, and the 4th pixel's address is still n+3.
- Bytes A5,08 with N_FRAMES=8 -> oErr=1, no writes, and the state returns to IDLE, so the next A5,01 is accepted with base 384000.
- iCS_n rises after 1000 bytes of a frame (333 pixels plus 1 byte) -> 333 writes, the partial pixel is discarded, oErr=1, oLoading=0.

Source files
------------

// File: rtl/mtl_pkg.sv
// Shared definitions for the MTL frame buffer: FSM/phase encodings, frame geometry
// defaults and the 0x00RRGGBB pixel word layout also used by the LCD read side.
package mtl_pkg;

   localparam int MTL_H_ACTIVE = 800;
   localparam int MTL_V_ACTIVE = 480;
   localparam int FRAME_PIXELS = MTL_H_ACTIVE * MTL_V_ACTIVE;
   localparam int PIX_CNT_W    = $clog2(FRAME_PIXELS);

   localparam int PIX_W   = 32;
   localparam int RED_LSB = 16;
   localparam int GRN_LSB = 8;
   localparam int BLU_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GET_IDX,
      ST_LOAD,
      ST_FLUSH
   } fsm_t;

   typedef enum logic [1:0] {
      PH_R,
      PH_G,
      PH_B
   } phase_t;

   function automatic logic [PIX_W-1:0] pack_pixel(input logic [7:0] r,
                                                   input logic [7:0] g,
                                                   input logic [7:0] b);
      logic [PIX_W-1:0] w;
      w = '0;
      w[RED_LSB +: 8] = r;
      w[GRN_LSB +: 8] = g;
      w[BLU_LSB +: 8] = b;
      return w;
   endfunction

endpackage

// File: rtl/mtl_wr_skid.sv
// Two-entry word+address buffer in front of the SDRAM write FIFO: an output
// register that holds steady while the FIFO is full, plus one skid entry behind it.
module mtl_wr_skid #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 22
) (
   input  logic              iCLK,
   input  logic              iRST_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic              wr_full,
   output logic              wr_en,
   output logic [DATA_W-1:0] wr_data,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              drop,
   output logic              empty_next
);

   logic              skid_v;
   logic [DATA_W-1:0] skid_data;
   logic [ADDR_W-1:0] skid_addr;
   logic              head_free;

   // The output register can take a new word if it is empty or being accepted now.
   assign head_free  = ~wr_en | ~wr_full;
   assign drop       = push & ~head_free & skid_v;
   assign empty_next = head_free & ~skid_v;

   // NOTE: the word registers are reset as well because they drive the write port
   // directly and must read zero out of reset.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         wr_en     <= 1'b0;
         wr_data   <= '0;
         wr_addr   <= '0;
         skid_v    <= 1'b0;
         skid_data <= '0;
         skid_addr <= '0;
      end else if (head_free) begin
         if (skid_v) begin
            wr_en   <= 1'b1;
            wr_data <= skid_data;
            wr_addr <= skid_addr;
            skid_v  <= push;
            if (push) begin
               skid_data <= push_data;
               skid_addr <= push_addr;
            end
         end else begin
            wr_en <= push;
            if (push) begin
               wr_data <= push_data;
               wr_addr <= push_addr;
            end
         end
      end else if (push && !skid_v) begin
         skid_v    <= 1'b1;
         skid_data <= push_data;
         skid_addr <= push_addr;
      end
   end

endmodule

// File: rtl/mtl_frame_writer.sv
// Write side of the slideshow frame buffer: parses header/index/RGB bytes from the
// SPI link and queues 0x00RRGGBB words at sequential SDRAM addresses.
module mtl_frame_writer
   import mtl_pkg::*;
#(
   parameter int         H_ACTIVE = MTL_H_ACTIVE,
   parameter int         V_ACTIVE = MTL_V_ACTIVE,
   parameter int         N_FRAMES = 8,
   parameter int         ADDR_W   = 22,
   parameter logic [7:0] HDR_BYTE = 8'hA5
) (
   input  logic              iCLK,
   input  logic              iRST_n,
   input  logic              iCS_n,
   input  logic [7:0]        iBYTE,
   input  logic              iBYTE_VALID,
   input  logic              iWR_FULL,
   output logic              oWR_EN,
   output logic [31:0]       oWR_DATA,
   output logic [ADDR_W-1:0] oWR_ADDR,
   output logic              oLoading,
   output logic              oFrameDone,
   output logic              oErr
);

   localparam int                FRAME_PX   = H_ACTIVE * V_ACTIVE;
   localparam int                CNT_W      = $clog2(FRAME_PX);
   localparam logic [CNT_W-1:0]  LAST_PIX   = CNT_W'(FRAME_PX - 1);
   localparam logic [ADDR_W-1:0] FRAME_SPAN = ADDR_W'(FRAME_PX);

   fsm_t              state;
   phase_t            phase;
   logic [7:0]        red;
   logic [7:0]        grn;
   logic [CNT_W-1:0]  pix_cnt;
   logic [ADDR_W-1:0] frame_base;
   logic              cs_q;
   logic              cs_rise;
   logic              pix_done;
   logic              drop;
   logic              empty_next;
   logic [PIX_W-1:0]  pix_word;
   logic [ADDR_W-1:0] pix_addr;

   assign cs_rise  = iCS_n & ~cs_q;
   assign pix_done = (state == ST_LOAD) & iBYTE_VALID & ~cs_rise & (phase == PH_B);
   assign pix_word = pack_pixel(red, grn, iBYTE);
   assign pix_addr = frame_base + ADDR_W'(pix_cnt);

   // NOTE: all state here uses non-blocking assignments so every branch decides on
   // the values held before the clock edge.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state      <= ST_IDLE;
         phase      <= PH_R;
         red        <= '0;
         grn        <= '0;
         pix_cnt    <= '0;
         frame_base <= '0;
         cs_q       <= 1'b1;
         oLoading   <= 1'b0;
         oFrameDone <= 1'b0;
         oErr       <= 1'b0;
      end else begin
         cs_q       <= iCS_n;
         oFrameDone <= 1'b0;
         if (drop) oErr <= 1'b1;

         unique case (state)
            ST_IDLE: begin
               if (iBYTE_VALID && iBYTE == HDR_BYTE) state <= ST_GET_IDX;
            end
            ST_GET_IDX: begin
               if (cs_rise) begin
                  oErr  <= 1'b1;
                  state <= ST_IDLE;
               end else if (iBYTE_VALID) begin
                  if (int'(iBYTE) < N_FRAMES) begin
                     frame_base <= FRAME_SPAN * ADDR_W'(iBYTE);
                     pix_cnt    <= '0;
                     phase      <= PH_R;
                     oLoading   <= 1'b1;
                     state      <= ST_LOAD;
                  end else begin
                     oErr  <= 1'b1;
                     state <= ST_IDLE;
                  end
               end
            end
            ST_LOAD: begin
               if (cs_rise) begin
                  oErr     <= 1'b1;
                  oLoading <= 1'b0;
                  phase    <= PH_R;
                  state    <= ST_IDLE;
               end else if (iBYTE_VALID) begin
                  case (phase)
                     PH_R: begin
                        red   <= iBYTE;
                        phase <= PH_G;
                     end
                     PH_G: begin
                        grn   <= iBYTE;
                        phase <= PH_B;
                     end
                     default: begin
                        phase <= PH_R;
                        // The completing pixel is always still in flight, so every frame ends via FLUSH.
                        if (pix_cnt == LAST_PIX) state <= ST_FLUSH;
                        else pix_cnt <= pix_cnt + 1'b1;
                     end
                  endcase
               end
            end
            ST_FLUSH: begin
               if (empty_next) begin
                  oFrameDone <= 1'b1;
                  oLoading   <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   mtl_wr_skid #(
      .DATA_W (PIX_W),
      .ADDR_W (ADDR_W)
   ) u_skid (
      .iCLK       (iCLK),
      .iRST_n     (iRST_n),
      .push       (pix_done),
      .push_data  (pix_word),
      .push_addr  (pix_addr),
      .wr_full    (iWR_FULL),
      .wr_en      (oWR_EN),
      .wr_data    (oWR_DATA),
      .wr_addr    (oWR_ADDR),
      .drop       (drop),
      .empty_next (empty_next)
   );

endmodule

// File: tb/tb_mtl_frame_writer.sv
// Directed-sequence bench with random pixel data; expected writes come from a
// frame/pixel-index model of the byte stream.
module tb_mtl_frame_writer;

   localparam int H   = 40;
   localparam int V   = 10;
   localparam int NF  = 8;
   localparam int AW  = 22;
   localparam int FPX = H * V;

   logic          iCLK = 1'b0;
   logic          iRST_n = 1'b1;
   logic          iCS_n = 1'b1;
   logic [7:0]    iBYTE = 8'h00;
   logic          iBYTE_VALID = 1'b0;
   logic          iWR_FULL = 1'b0;
   logic          oWR_EN;
   logic [31:0]   oWR_DATA;
   logic [AW-1:0] oWR_ADDR;
   logic          oLoading;
   logic          oFrameDone;
   logic          oErr;

   mtl_frame_writer #(
      .H_ACTIVE (H),
      .V_ACTIVE (V),
      .N_FRAMES (NF),
      .ADDR_W   (AW),
      .HDR_BYTE (8'hA5)
   ) dut (
      .iCLK        (iCLK),
      .iRST_n      (iRST_n),
      .iCS_n       (iCS_n),
      .iBYTE       (iBYTE),
      .iBYTE_VALID (iBYTE_VALID),
      .iWR_FULL    (iWR_FULL),
      .oWR_EN      (oWR_EN),
      .oWR_DATA    (oWR_DATA),
      .oWR_ADDR    (oWR_ADDR),
      .oLoading    (oLoading),
      .oFrameDone  (oFrameDone),
      .oErr        (oErr)
   );

   always #5 iCLK = ~iCLK;

   typedef logic [AW+31:0] wr_t;

   wr_t obs_q[$];
   wr_t exp_q[$];
   int  obs_rd = 0;
   int  n_checks = 0;
   int  n_fail = 0;
   int  cyc = 0;
   int  done_cnt = 0;
   int  done_cyc = -1;
   int  last_wr_cyc = -1;
   int  hold_viol = 0;
   logic prev_stall = 1'b0;
   wr_t  prev_wr = '0;
   int  cur_frame = 0;
   int  cur_idx = 0;
   int  done_base = 0;

   always @(posedge iCLK) cyc <= cyc + 1;

   // Write-port monitor: records accepted words, frame-done pulses and hold violations.
   always @(negedge iCLK) begin
      if (!iRST_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && !(oWR_EN && {oWR_ADDR, oWR_DATA} === prev_wr)) hold_viol++;
         if (oWR_EN && !iWR_FULL) begin
            obs_q.push_back({oWR_ADDR, oWR_DATA});
            last_wr_cyc = cyc;
         end
         if (oFrameDone) begin
            done_cnt++;
            done_cyc = cyc;
         end
         prev_stall = oWR_EN && iWR_FULL;
         prev_wr    = {oWR_ADDR, oWR_DATA};
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic strobe(input logic [7:0] b);
      iBYTE       = b;
      iBYTE_VALID = 1'b1;
      tick();
      iBYTE_VALID = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      strobe(b);
      tick();
   endtask

   task automatic start_frame(input int f);
      send_byte(8'hA5);
      send_byte(8'(f));
      cur_frame = f;
      cur_idx   = 0;
   endtask

   task automatic model_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                              input bit dropped);
      if (!dropped) exp_q.push_back({AW'(cur_frame * FPX + cur_idx), 8'h00, r, g, b});
      cur_idx++;
   endtask

   task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                             input bit dropped);
      send_byte(r);
      send_byte(g);
      send_byte(b);
      model_pixel(r, g, b, dropped);
   endtask

   task automatic send_rand_pixel(input bit dropped);
      logic [7:0] r, g, b;
      r = 8'($urandom);
      g = 8'($urandom);
      b = 8'($urandom);
      send_pixel(r, g, b, dropped);
   endtask

   task automatic compare_writes(input string tag);
      int n_obs;
      repeat (4) tick();
      n_obs = obs_q.size() - obs_rd;
      check({tag, "_count"}, 64'(n_obs), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (obs_rd + i < obs_q.size())
            check($sformatf("%s[%0d]", tag, i), 64'(obs_q[obs_rd + i]), 64'(exp_q[i]));
      end
      obs_rd = obs_q.size();
      exp_q.delete();
   endtask

   task automatic apply_reset(input string tag);
      iRST_n = 1'b0;
      #2;
      check({tag, "_wr_en"}, 64'(oWR_EN), 64'd0);
      check({tag, "_wr_data"}, 64'(oWR_DATA), 64'd0);
      check({tag, "_wr_addr"}, 64'(oWR_ADDR), 64'd0);
      check({tag, "_loading"}, 64'(oLoading), 64'd0);
      check({tag, "_frame_done"}, 64'(oFrameDone), 64'd0);
      check({tag, "_err"}, 64'(oErr), 64'd0);
      tick();
      iRST_n = 1'b1;
      tick();
      obs_rd = obs_q.size();
      exp_q.delete();
   endtask

   initial begin
      #2;
      apply_reset("por");
      iCS_n = 1'b0;
      tick();

      // Single pixel into frame 2, then reset in the middle of that frame.
      done_base = done_cnt;
      start_frame(2);
      check("idx2_loading", 64'(oLoading), 64'd1);
      send_byte(8'h11);
      send_byte(8'h22);
      strobe(8'h33);
      check("px_wr_en", 64'(oWR_EN), 64'd1);
      check("px_wr_data", 64'(oWR_DATA), 64'h0011_2233);
      check("px_wr_addr", 64'(oWR_ADDR), 64'(2 * FPX));
      tick();
      check("px_wr_en_one_cycle", 64'(oWR_EN), 64'd0);
      model_pixel(8'h11, 8'h22, 8'h33, 1'b0);
      for (int i = 0; i < 99; i++) send_rand_pixel(1'b0);
      compare_writes("frame2_100px");
      check("frame2_no_done", 64'(done_cnt - done_base), 64'd0);
      check("frame2_loading_before_rst", 64'(oLoading), 64'd1);
      apply_reset("midload_rst");

      // Full frame 0 with no back-pressure; first pixel uses header-valued bytes.
      done_base = done_cnt;
      start_frame(0);
      send_pixel(8'hA5, 8'hA5, 8'hA5, 1'b0);
      for (int i = 1; i < FPX; i++) send_rand_pixel(1'b0);
      compare_writes("full_frame0");
      check("full_done_once", 64'(done_cnt - done_base), 64'd1);
      check("full_done_after_last_wr", 64'(done_cyc > last_wr_cyc), 64'd1);
      check("full_loading_after", 64'(oLoading), 64'd0);
      check("full_err", 64'(oErr), 64'd0);

      // Back-pressure: two pixels fit, the third is dropped, addressing stays aligned.
      apply_reset("stall_rst");
      start_frame(3);
      send_rand_pixel(1'b0);
      repeat (3) tick();
      iWR_FULL = 1'b1;
      send_rand_pixel(1'b0);
      send_rand_pixel(1'b0);
      repeat (3) tick();
      check("stall_err_two_queued", 64'(oErr), 64'd0);
      check("stall_no_new_writes", 64'(obs_q.size() - obs_rd), 64'd1);
      check("stall_head_en", 64'(oWR_EN), 64'd1);
      check("stall_head_addr", 64'(oWR_ADDR), 64'(3 * FPX + 1));
      send_rand_pixel(1'b1);
      check("stall_overflow_err", 64'(oErr), 64'd1);
      iWR_FULL = 1'b0;
      repeat (3) tick();
      send_rand_pixel(1'b0);
      compare_writes("stall_writes");
      check("stall_hold_stable", 64'(hold_viol), 64'd0);

      // Out-of-range frame index, then a valid one.
      apply_reset("badidx_rst");
      send_byte(8'hA5);
      send_byte(8'(NF));
      check("badidx_err", 64'(oErr), 64'd1);
      check("badidx_loading", 64'(oLoading), 64'd0);
      repeat (5) tick();
      start_frame(1);
      check("idx1_loading", 64'(oLoading), 64'd1);
      send_rand_pixel(1'b0);
      compare_writes("badidx_then_idx1");

      // Abort after 1000 bytes of frame 5: 333 pixels plus one stray byte.
      apply_reset("abort_rst");
      done_base = done_cnt;
      start_frame(5);
      for (int i = 0; i < 333; i++) send_rand_pixel(1'b0);
      send_byte(8'($urandom));
      iCS_n = 1'b1;
      repeat (3) tick();
      check("abort_err", 64'(oErr), 64'd1);
      check("abort_loading", 64'(oLoading), 64'd0);
      compare_writes("abort_333px");
      iCS_n = 1'b0;
      tick();
      start_frame(6);
      send_rand_pixel(1'b0);
      compare_writes("after_abort_idx6");
      check("abort_no_done", 64'(done_cnt - done_base), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
